// File: rtl/wb_writeback_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_writeback_arbiter_pkg
// Purpose  : Shared writeback-select codes, load FUNC3 codes and source enum.
// Revision : 1.0  initial release
// ============================================================================
package wb_writeback_arbiter_pkg;

    localparam int c_xlen = 32;

    localparam logic [1:0] c_wb_sel_alu  = 2'b00;
    localparam logic [1:0] c_wb_sel_load = 2'b01;
    localparam logic [1:0] c_wb_sel_pc4  = 2'b10;
    localparam logic [1:0] c_wb_sel_rsvd = 2'b11;

    localparam logic [2:0] c_f3_lb  = 3'b000;
    localparam logic [2:0] c_f3_lh  = 3'b001;
    localparam logic [2:0] c_f3_lw  = 3'b010;
    localparam logic [2:0] c_f3_lbu = 3'b100;
    localparam logic [2:0] c_f3_lhu = 3'b101;

    typedef enum logic [1:0] {
        WB_SRC_NONE = 2'd0,
        WB_SRC_PIPE = 2'd1,
        WB_SRC_MDU  = 2'd2
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/wb_writeback_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_writeback_arbiter_if
// Purpose  : MEM-stage, MDU handshake and register-file write bundle.
// Revision : 1.0  initial release
// ============================================================================
interface wb_writeback_arbiter_if
    import wb_writeback_arbiter_pkg::*;
#(
    parameter int XLEN = c_xlen
);
    logic            mem_valid;
    logic            mem_reg_write;
    logic [4:0]      mem_rd;
    logic [1:0]      mem_wb_sel;
    logic [2:0]      mem_func3;
    logic [1:0]      mem_addr_lo;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_load_data;
    logic [XLEN-1:0] mem_pc_plus4;
    logic            mdu_valid;
    logic [4:0]      mdu_rd;
    logic [XLEN-1:0] mdu_result;
    logic            mdu_ready;
    logic            stall_req;
    logic            write_enable;
    logic [4:0]      write_addr;
    logic [XLEN-1:0] write_data;

    modport master (
        output mem_valid, mem_reg_write, mem_rd, mem_wb_sel, mem_func3, mem_addr_lo,
               mem_alu_result, mem_load_data, mem_pc_plus4,
               mdu_valid, mdu_rd, mdu_result,
        input  mdu_ready, stall_req, write_enable, write_addr, write_data
    );

    modport slave (
        input  mem_valid, mem_reg_write, mem_rd, mem_wb_sel, mem_func3, mem_addr_lo,
               mem_alu_result, mem_load_data, mem_pc_plus4,
               mdu_valid, mdu_rd, mdu_result,
        output mdu_ready, stall_req, write_enable, write_addr, write_data
    );

endinterface
`default_nettype wire

// File: rtl/wb_writeback_arbiter_load_align.sv
`default_nettype none
// ============================================================================
// Module   : wb_writeback_arbiter_load_align
// Purpose  : Combinational load-data alignment and sign/zero extension.
// Revision : 1.0  initial release
// ============================================================================
module wb_writeback_arbiter_load_align
    import wb_writeback_arbiter_pkg::*;
#(
    parameter int XLEN = c_xlen
)(
    input  wire logic [2:0]      i_func3,
    input  wire logic [1:0]      i_addr_lo,
    input  wire logic [XLEN-1:0] i_word,
    output logic      [XLEN-1:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            2'd3:    w_byte = i_word[31:24];
            default: w_byte = i_word[7:0];
        endcase
        // Halfword selection uses only the upper offset bit; misaligned halves are not split.
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_result = i_word;
        case (i_func3)
            c_f3_lb:  o_result = {{(XLEN-8){w_byte[7]}}, w_byte};
            c_f3_lh:  o_result = {{(XLEN-16){w_half[15]}}, w_half};
            c_f3_lbu: o_result = {{(XLEN-8){1'b0}}, w_byte};
            c_f3_lhu: o_result = {{(XLEN-16){1'b0}}, w_half};
            default:  o_result = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_writeback_arbiter
// Purpose  : MEM/WB register and writeback arbiter merging pipeline and MDU results.
// Revision : 1.0  initial release
// ============================================================================
module wb_writeback_arbiter
    import wb_writeback_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = c_xlen
)(
    input  wire logic CLK,
    input  wire logic RESET,
    wb_writeback_arbiter_if.slave bus
);

    localparam int                 c_cnt_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);

    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_write_enable;
    logic [4:0]         r_write_addr;
    logic [XLEN-1:0]    r_write_data;

    logic               w_pipe_wr;
    logic               w_stall;
    logic               w_mdu_ready;
    wb_src_e            w_src;
    logic [XLEN-1:0]    w_load_data;
    logic [XLEN-1:0]    w_pipe_data;

    wb_writeback_arbiter_load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .i_func3   (bus.mem_func3),
        .i_addr_lo (bus.mem_addr_lo),
        .i_word    (bus.mem_load_data),
        .o_result  (w_load_data)
    );

    always_comb begin
        w_pipe_wr   = bus.mem_valid & bus.mem_reg_write & (bus.mem_rd != 5'd0);
        w_stall     = bus.mdu_valid & (r_wait_cnt == c_limit);
        w_mdu_ready = bus.mdu_valid & (w_stall | ~w_pipe_wr);
    end

    // Reserved select code falls through to the ALU result.
    always_comb begin
        w_pipe_data = bus.mem_alu_result;
        case (bus.mem_wb_sel)
            c_wb_sel_load: w_pipe_data = w_load_data;
            c_wb_sel_pc4:  w_pipe_data = bus.mem_pc_plus4;
            default:       w_pipe_data = bus.mem_alu_result;
        endcase
    end

    always_comb begin
        w_src = WB_SRC_NONE;
        if (w_stall) begin
            w_src = WB_SRC_MDU;
        end else if (w_pipe_wr) begin
            w_src = WB_SRC_PIPE;
        end else if (bus.mdu_valid) begin
            w_src = WB_SRC_MDU;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wait_cnt <= '0;
        end else if (!bus.mdu_valid || w_mdu_ready) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != c_limit) begin
            r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
        end
    end

    // A bubble keeps address/data so the forwarding source stays stable.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_write_enable <= 1'b0;
            r_write_addr   <= 5'd0;
            r_write_data   <= '0;
        end else begin
            case (w_src)
                WB_SRC_PIPE: begin
                    r_write_enable <= 1'b1;
                    r_write_addr   <= bus.mem_rd;
                    r_write_data   <= w_pipe_data;
                end
                WB_SRC_MDU: begin
                    r_write_enable <= (bus.mdu_rd != 5'd0);
                    r_write_addr   <= bus.mdu_rd;
                    r_write_data   <= bus.mdu_result;
                end
                default: begin
                    r_write_enable <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mdu_ready    = w_mdu_ready;
    assign bus.stall_req    = w_stall;
    assign bus.write_enable = r_write_enable;
    assign bus.write_addr   = r_write_addr;
    assign bus.write_data   = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_writeback_arbiter
// Purpose  : Directed scoreboard bench for the writeback arbiter with a small reg file.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_writeback_arbiter;
    import wb_writeback_arbiter_pkg::*;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        chk_ad;
    } wb_exp_t;

    logic        CLK;
    logic        RESET;
    int          checks;
    int          failures;
    wb_exp_t     sb[$];
    logic [31:0] rf [32];
    logic [4:0]  out_addr1;
    logic [31:0] out_data1;

    wb_writeback_arbiter_if #(.XLEN(32)) bus ();

    wb_writeback_arbiter #(
        .STARVE_LIMIT (4),
        .XLEN         (32)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (bus.write_enable && bus.write_addr != 5'd0) begin
            rf[bus.write_addr] <= bus.write_data;
        end
    end
    assign out_data1 = (out_addr1 == 5'd0) ? 32'd0 : rf[out_addr1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_pipe(input logic v, input logic rw, input logic [4:0] rd,
                              input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] lo,
                              input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc);
        bus.mem_valid      = v;
        bus.mem_reg_write  = rw;
        bus.mem_rd         = rd;
        bus.mem_wb_sel     = sel;
        bus.mem_func3      = f3;
        bus.mem_addr_lo    = lo;
        bus.mem_alu_result = alu;
        bus.mem_load_data  = ld;
        bus.mem_pc_plus4   = pc;
    endtask

    task automatic drive_mdu(input logic v, input logic [4:0] rd, input logic [31:0] res);
        bus.mdu_valid  = v;
        bus.mdu_rd     = rd;
        bus.mdu_result = res;
    endtask

    // One clock: checks handshake outputs, queues the expected WB result, then compares it after the edge.
    task automatic cycle(input string tag, input logic we, input logic [4:0] addr,
                         input logic [31:0] data, input logic chk_ad,
                         input logic exp_ready, input logic exp_stall);
        wb_exp_t e;
        #1;
        check({tag, ".mdu_ready"}, {31'd0, bus.mdu_ready}, {31'd0, exp_ready});
        check({tag, ".stall_req"}, {31'd0, bus.stall_req}, {31'd0, exp_stall});
        sb.push_back('{we, addr, data, chk_ad});
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check({tag, ".write_enable"}, {31'd0, bus.write_enable}, {31'd0, e.we});
        if (e.chk_ad) begin
            check({tag, ".write_addr"}, {27'd0, bus.write_addr}, {27'd0, e.addr});
            check({tag, ".write_data"}, bus.write_data, e.data);
        end
    endtask

    task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        out_addr1 = a;
        #1;
        check(tag, out_data1, exp);
    endtask

    task automatic sync();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        out_addr1 = 5'd0;
        RESET     = 1'b1;
        drive_pipe(1'b0, 1'b0, 5'd0, c_wb_sel_alu, c_f3_lw, 2'd0, 32'd0, 32'd0, 32'd0);
        drive_mdu(1'b0, 5'd0, 32'd0);

        // Reset state
        cycle("rst0", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        cycle("rst1", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        RESET = 1'b0;
        for (int i = 1; i < 32; i++) read_check($sformatf("rst_x%0d", i), 5'(i), 32'd0);
        sync();

        // ALU then PC+4 on consecutive cycles
        drive_pipe(1'b1, 1'b1, 5'd1, c_wb_sel_alu, c_f3_lw, 2'd0, 32'd42, 32'hDEAD_BEEF, 32'h0000_00FC);
        cycle("alu_x1", 1'b1, 5'd1, 32'd42, 1'b1, 1'b0, 1'b0);
        drive_pipe(1'b1, 1'b1, 5'd2, c_wb_sel_pc4, c_f3_lw, 2'd0, 32'h55, 32'hDEAD_BEEF, 32'h0000_0104);
        cycle("pc4_x2", 1'b1, 5'd2, 32'h104, 1'b1, 1'b0, 1'b0);
        drive_pipe(1'b0, 1'b0, 5'd0, c_wb_sel_alu, c_f3_lw, 2'd0, 32'd0, 32'd0, 32'd0);
        cycle("idle_a", 1'b0, 5'd2, 32'h104, 1'b1, 1'b0, 1'b0);
        read_check("rf_x1", 5'd1, 32'd42);
        read_check("rf_x2", 5'd2, 32'h104);
        sync();

        // Load alignment and extension
        drive_pipe(1'b1, 1'b1, 5'd3, c_wb_sel_load, c_f3_lb, 2'd1, 32'h1111_1111, 32'h8899_AABB, 32'd0);
        cycle("lb_1", 1'b1, 5'd3, 32'hFFFF_FFAA, 1'b1, 1'b0, 1'b0);
        drive_pipe(1'b1, 1'b1, 5'd4, c_wb_sel_load, c_f3_lbu, 2'd3, 32'h1111_1111, 32'h8899_AABB, 32'd0);
        cycle("lbu_3", 1'b1, 5'd4, 32'h0000_0088, 1'b1, 1'b0, 1'b0);
        drive_pipe(1'b1, 1'b1, 5'd5, c_wb_sel_load, c_f3_lh, 2'd2, 32'h1111_1111, 32'h8899_AABB, 32'd0);
        cycle("lh_2", 1'b1, 5'd5, 32'hFFFF_8899, 1'b1, 1'b0, 1'b0);
        drive_pipe(1'b1, 1'b1, 5'd6, c_wb_sel_load, c_f3_lhu, 2'd0, 32'h1111_1111, 32'h8899_AABB, 32'd0);
        cycle("lhu_0", 1'b1, 5'd6, 32'h0000_AABB, 1'b1, 1'b0, 1'b0);
        drive_pipe(1'b1, 1'b1, 5'd7, c_wb_sel_load, c_f3_lw, 2'd2, 32'h1111_1111, 32'h8899_AABB, 32'd0);
        cycle("lw_2", 1'b1, 5'd7, 32'h8899_AABB, 1'b1, 1'b0, 1'b0);
        drive_pipe(1'b1, 1'b1, 5'd8, c_wb_sel_load, 3'b011, 2'd1, 32'h1111_1111, 32'h1234_5678, 32'd0);
        cycle("f3_undef", 1'b1, 5'd8, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        drive_pipe(1'b1, 1'b1, 5'd9, c_wb_sel_rsvd, c_f3_lw, 2'd0, 32'h0000_0999, 32'h1234_5678, 32'h4);
        cycle("sel_rsvd", 1'b1, 5'd9, 32'h0000_0999, 1'b1, 1'b0, 1'b0);

        // rd=0 is a bubble: address/data hold
        drive_pipe(1'b1, 1'b1, 5'd0, c_wb_sel_alu, c_f3_lw, 2'd0, 32'd123, 32'd0, 32'd0);
        cycle("rd0", 1'b0, 5'd9, 32'h0000_0999, 1'b1, 1'b0, 1'b0);
        drive_pipe(1'b0, 1'b0, 5'd0, c_wb_sel_alu, c_f3_lw, 2'd0, 32'd0, 32'd0, 32'd0);
        cycle("idle_b", 1'b0, 5'd9, 32'h0000_0999, 1'b1, 1'b0, 1'b0);
        read_check("rf_x0", 5'd0, 32'd0);
        read_check("rf_x3", 5'd3, 32'hFFFF_FFAA);
        read_check("rf_x6", 5'd6, 32'h0000_AABB);
        sync();

        // MDU starved by four pipeline writes, then forced through
        drive_mdu(1'b1, 5'd5, 32'd100);
        for (int i = 0; i < 4; i++) begin
            drive_pipe(1'b1, 1'b1, 5'(10 + i), c_wb_sel_alu, c_f3_lw, 2'd0, 32'h1000 + 32'(i), 32'd0, 32'd0);
            cycle($sformatf("starve%0d", i), 1'b1, 5'(10 + i), 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0);
        end
        drive_pipe(1'b1, 1'b1, 5'd14, c_wb_sel_alu, c_f3_lw, 2'd0, 32'h2000, 32'd0, 32'd0);
        cycle("forced", 1'b1, 5'd5, 32'd100, 1'b1, 1'b1, 1'b1);
        drive_mdu(1'b0, 5'd0, 32'd0);
        cycle("replay", 1'b1, 5'd14, 32'h2000, 1'b1, 1'b0, 1'b0);
        drive_pipe(1'b0, 1'b0, 5'd0, c_wb_sel_alu, c_f3_lw, 2'd0, 32'd0, 32'd0, 32'd0);
        cycle("idle_c", 1'b0, 5'd14, 32'h2000, 1'b1, 1'b0, 1'b0);
        read_check("rf_x5_mdu", 5'd5, 32'd100);
        read_check("rf_x13", 5'd13, 32'h1003);
        read_check("rf_x14", 5'd14, 32'h2000);
        sync();

        // MDU with idle pipeline is accepted immediately
        drive_mdu(1'b1, 5'd5, 32'd200);
        cycle("mdu_free", 1'b1, 5'd5, 32'd200, 1'b1, 1'b1, 1'b0);
        drive_mdu(1'b1, 5'd0, 32'h77);
        cycle("mdu_rd0", 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        drive_mdu(1'b0, 5'd0, 32'd0);
        cycle("idle_d", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        read_check("rf_x5_free", 5'd5, 32'd200);
        read_check("rf_x0_mdu", 5'd0, 32'd0);
        sync();

        // Reset while the MDU waits clears the starvation count
        drive_mdu(1'b1, 5'd16, 32'd77);
        drive_pipe(1'b1, 1'b1, 5'd15, c_wb_sel_alu, c_f3_lw, 2'd0, 32'h15, 32'd0, 32'd0);
        cycle("pre_rst0", 1'b1, 5'd15, 32'h15, 1'b1, 1'b0, 1'b0);
        cycle("pre_rst1", 1'b1, 5'd15, 32'h15, 1'b1, 1'b0, 1'b0);
        RESET = 1'b1;
        cycle("mid_rst", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle($sformatf("post_rst%0d", i), 1'b1, 5'd15, 32'h15, 1'b1, 1'b0, 1'b0);
        end
        cycle("post_forced", 1'b1, 5'd16, 32'd77, 1'b1, 1'b1, 1'b1);
        drive_mdu(1'b0, 5'd0, 32'd0);
        drive_pipe(1'b0, 1'b0, 5'd0, c_wb_sel_alu, c_f3_lw, 2'd0, 32'd0, 32'd0, 32'd0);
        cycle("idle_e", 1'b0, 5'd16, 32'd77, 1'b1, 1'b0, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
